// File: rtl/dcache_fill_fsm_pkg.sv
// ============================================================================
// Module   : dcache_fill_fsm_pkg
// Brief    : Shared types and geometry constants for the data-cache fill path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dcache_fill_fsm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_FILL = 2'b01,
      ST_META = 2'b10
   } fill_state_t;

   localparam int C_WORDS  = 8;
   localparam int C_WOFF_W = 3;
   localparam int C_BOFF_W = 4;

   // Word offset sits above the byte-select bit; base has a zero block offset,
   // so concatenation replaces addition and can never carry into the tag.
   function automatic logic [15:0] word_addr(input logic [15:0]         base,
                                             input logic [C_WOFF_W-1:0] idx);
      return {base[15:C_BOFF_W], idx, 1'b0};
   endfunction

endpackage

`default_nettype wire

// File: rtl/dcache_fill_fsm_word_counter.sv
// ============================================================================
// Module   : fill_word_counter
// Brief    : 3-bit enabled word counter with sync clear and sticky done flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fill_word_counter
   import dcache_fill_fsm_pkg::*;
#(
   parameter logic [C_WOFF_W-1:0] LAST = 3'd7
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr,
   input  logic                en,
   output logic [C_WOFF_W-1:0] count,
   output logic                at_last,
   output logic                done
);

   logic [C_WOFF_W-1:0] r_count;
   logic                r_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
         r_done  <= 1'b0;
      end else if (clr) begin
         r_count <= '0;
         r_done  <= 1'b0;
      end else if (en) begin
         r_count <= r_count + 1'b1;
         if (r_count == LAST) begin
            r_done <= 1'b1;
         end
      end
   end

   assign count   = r_count;
   assign at_last = (r_count == LAST);
   assign done    = r_done;

endmodule

`default_nettype wire

// File: rtl/dcache_fill_fsm.sv
// ============================================================================
// Module   : dcache_fill_fsm
// Brief    : Data-cache miss handler: fetches an 8-word block and commits it.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_fill_fsm
   import dcache_fill_fsm_pkg::*;
#(
   parameter int MEM_LAT = 4,
   parameter int WORDS   = C_WORDS
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        Miss,
   input  logic [15:0] Addr_CPU,
   input  logic [15:0] mem_data,
   input  logic        mem_data_valid,
   output logic        mem_en,
   output logic [15:0] mem_addr,
   output logic [15:0] Addr_FSM,
   output logic [15:0] DataIn_FSM,
   output logic        Data_WE,
   output logic        MetaData_WE,
   output logic        stall_fill
);

   localparam logic [C_WOFF_W-1:0] C_LAST = C_WOFF_W'(WORDS - 1);

   // Latency only shapes the memory side; the receive path just follows valids.
   generate
      if (MEM_LAT < 1) begin : g_lat_guard
      end
   endgenerate

   fill_state_t         r_state;
   fill_state_t         w_state_nxt;
   logic [15:0]         r_base;
   logic                w_latch;
   logic                w_fill;
   logic                w_issue;
   logic                w_recv;
   logic                w_clr;
   logic [C_WOFF_W-1:0] w_issue_cnt;
   logic [C_WOFF_W-1:0] w_recv_cnt;
   logic                w_issue_done;
   logic                w_recv_done;
   logic                w_recv_last;
   logic                w_issue_last;

   assign w_fill  = (r_state == ST_FILL);
   assign w_issue = w_fill & ~w_issue_done;
   assign w_recv  = w_fill & mem_data_valid & ~w_recv_done;
   assign w_clr   = (r_state == ST_META);

   fill_word_counter #(.LAST(C_LAST)) u_issue_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (w_clr),
      .en      (w_issue),
      .count   (w_issue_cnt),
      .at_last (w_issue_last),
      .done    (w_issue_done)
   );

   fill_word_counter #(.LAST(C_LAST)) u_recv_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (w_clr),
      .en      (w_recv),
      .count   (w_recv_cnt),
      .at_last (w_recv_last),
      .done    (w_recv_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_base  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_latch) begin
            r_base <= {Addr_CPU[15:C_BOFF_W], {C_BOFF_W{1'b0}}};
         end
      end
   end

   // A miss still pending during the commit cycle chains straight into the next fill.
   always_comb begin
      w_state_nxt = r_state;
      w_latch     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (Miss) begin
               w_latch     = 1'b1;
               w_state_nxt = ST_FILL;
            end
         end
         ST_FILL: begin
            if (w_recv && w_recv_last) begin
               w_state_nxt = ST_META;
            end
         end
         ST_META: begin
            if (Miss) begin
               w_latch     = 1'b1;
               w_state_nxt = ST_FILL;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign mem_en      = w_issue;
   assign mem_addr    = w_issue ? word_addr(r_base, w_issue_cnt) : 16'h0000;
   assign Data_WE     = w_recv;
   assign DataIn_FSM  = w_recv ? mem_data : 16'h0000;
   assign Addr_FSM    = w_recv ? word_addr(r_base, w_recv_cnt) : r_base;
   assign MetaData_WE = (r_state == ST_META);
   assign stall_fill  = Miss | (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_dcache_fill_fsm.sv
// ============================================================================
// Module   : tb_dcache_fill_fsm
// Brief    : Directed self-checking bench for the data-cache fill FSM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dcache_fill_fsm;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        Miss;
   logic [15:0] Addr_CPU;
   logic [15:0] mem_data;
   logic        mem_data_valid;
   logic        mem_en;
   logic [15:0] mem_addr;
   logic [15:0] Addr_FSM;
   logic [15:0] DataIn_FSM;
   logic        Data_WE;
   logic        MetaData_WE;
   logic        stall_fill;

   int checks = 0;
   int errors = 0;

   logic [3:0]  r_vld_sr;
   logic [15:0] r_a_sr [4];
   logic        spur_v;
   logic [15:0] spur_d;

   always #5 clk = ~clk;

   dcache_fill_fsm #(.MEM_LAT(4), .WORDS(8)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .Miss           (Miss),
      .Addr_CPU       (Addr_CPU),
      .mem_data       (mem_data),
      .mem_data_valid (mem_data_valid),
      .mem_en         (mem_en),
      .mem_addr       (mem_addr),
      .Addr_FSM       (Addr_FSM),
      .DataIn_FSM     (DataIn_FSM),
      .Data_WE        (Data_WE),
      .MetaData_WE    (MetaData_WE),
      .stall_fill     (stall_fill)
   );

   // Pipelined memory, 4-cycle latency; data word is address XOR 0x5A5A.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld_sr <= '0;
         for (int i = 0; i < 4; i++) r_a_sr[i] <= '0;
      end else begin
         r_vld_sr <= {r_vld_sr[2:0], mem_en};
         r_a_sr[0] <= mem_addr;
         for (int i = 1; i < 4; i++) r_a_sr[i] <= r_a_sr[i-1];
      end
   end

   assign mem_data_valid = r_vld_sr[3] | spur_v;
   assign mem_data       = spur_v ? spur_d : (r_vld_sr[3] ? (r_a_sr[3] ^ 16'h5A5A) : 16'h0000);

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   // Expected outputs for cycle c of a fill whose miss was seen at cycle 0.
   task automatic check_fill(input logic [15:0] b, input int c);
      logic        e_en, e_we, e_meta, e_stall;
      logic [15:0] e_maddr, e_aflm, e_din;
      #1;
      e_en    = (c >= 1) && (c <= 8);
      e_we    = (c >= 5) && (c <= 12);
      e_meta  = (c == 13);
      e_stall = (c <= 13) || Miss;
      e_maddr = e_en ? (b + 16'(2 * (c - 1))) : 16'h0000;
      e_aflm  = e_we ? (b + 16'(2 * (c - 5))) : b;
      e_din   = e_we ? ((b + 16'(2 * (c - 5))) ^ 16'h5A5A) : 16'h0000;
      chk($sformatf("mem_en b=%h c%0d", b, c), 16'(mem_en), 16'(e_en));
      chk($sformatf("mem_addr b=%h c%0d", b, c), mem_addr, e_maddr);
      chk($sformatf("Data_WE b=%h c%0d", b, c), 16'(Data_WE), 16'(e_we));
      chk($sformatf("DataIn_FSM b=%h c%0d", b, c), DataIn_FSM, e_din);
      chk($sformatf("MetaData_WE b=%h c%0d", b, c), 16'(MetaData_WE), 16'(e_meta));
      chk($sformatf("stall_fill b=%h c%0d", b, c), 16'(stall_fill), 16'(e_stall));
      if (c != 0) chk($sformatf("Addr_FSM b=%h c%0d", b, c), Addr_FSM, e_aflm);
   endtask

   task automatic check_all_zero(input string tag);
      #1;
      chk({tag, " mem_en"},      16'(mem_en),      16'h0);
      chk({tag, " mem_addr"},    mem_addr,         16'h0);
      chk({tag, " Addr_FSM"},    Addr_FSM,         16'h0);
      chk({tag, " DataIn_FSM"},  DataIn_FSM,       16'h0);
      chk({tag, " Data_WE"},     16'(Data_WE),     16'h0);
      chk({tag, " MetaData_WE"}, 16'(MetaData_WE), 16'h0);
      chk({tag, " stall_fill"},  16'(stall_fill),  16'h0);
   endtask

   initial begin
      rst_n    = 1'b0;
      Miss     = 1'b0;
      Addr_CPU = 16'h0000;
      spur_v   = 1'b0;
      spur_d   = 16'h0000;

      // Reset state
      #12;
      check_all_zero("reset");
      rst_n = 1'b1;
      tick;

      // Single fill from 0x1236
      tick;
      Miss = 1'b1; Addr_CPU = 16'h1236;
      check_fill(16'h1230, 0);
      for (int c = 1; c <= 14; c++) begin
         tick;
         if (c == 1) Miss = 1'b0;
         check_fill(16'h1230, c);
      end

      // Spurious valid while idle
      tick;
      spur_v = 1'b1; spur_d = 16'hBEEF;
      #1;
      chk("spur Data_WE",     16'(Data_WE),     16'h0);
      chk("spur MetaData_WE", 16'(MetaData_WE), 16'h0);
      chk("spur stall_fill",  16'(stall_fill),  16'h0);
      chk("spur DataIn_FSM",  DataIn_FSM,       16'h0);
      tick;
      spur_v = 1'b0;

      // Miss re-pulse mid-fill with a different address
      tick;
      Miss = 1'b1; Addr_CPU = 16'h1236;
      check_fill(16'h1230, 0);
      for (int c = 1; c <= 14; c++) begin
         tick;
         if (c == 1) Miss = 1'b0;
         if (c == 3) begin Miss = 1'b1; Addr_CPU = 16'h8000; end
         if (c == 4) Miss = 1'b0;
         check_fill(16'h1230, c);
      end
      for (int k = 0; k < 3; k++) begin
         tick;
         #1;
         chk($sformatf("repulse no burst k%0d", k), 16'(mem_en), 16'h0);
      end

      // Reset mid-fill, then a fresh fill from a zero count
      tick;
      Miss = 1'b1; Addr_CPU = 16'h1236;
      check_fill(16'h1230, 0);
      for (int c = 1; c <= 6; c++) begin
         tick;
         if (c == 1) Miss = 1'b0;
         check_fill(16'h1230, c);
      end
      tick;
      rst_n = 1'b0;
      check_all_zero("midreset");
      tick;
      rst_n = 1'b1;
      tick;
      tick;
      Miss = 1'b1; Addr_CPU = 16'h0040;
      check_fill(16'h0040, 0);
      for (int c = 1; c <= 14; c++) begin
         tick;
         if (c == 1) Miss = 1'b0;
         check_fill(16'h0040, c);
      end

      // Top of memory, with stray valids in META and the following idle cycle
      tick;
      Miss = 1'b1; Addr_CPU = 16'hFFFA;
      check_fill(16'hFFF0, 0);
      for (int c = 1; c <= 14; c++) begin
         tick;
         if (c == 1) Miss = 1'b0;
         if (c == 13) begin spur_v = 1'b1; spur_d = 16'hBEEF; end
         check_fill(16'hFFF0, c);
      end
      spur_v = 1'b0;

      // Back-to-back misses: Miss held across META into a second block
      tick;
      Miss = 1'b1; Addr_CPU = 16'h1236;
      check_fill(16'h1230, 0);
      for (int c = 1; c <= 13; c++) begin
         tick;
         if (c == 13) Addr_CPU = 16'h2468;
         check_fill(16'h1230, c);
      end
      for (int c = 1; c <= 14; c++) begin
         tick;
         if (c == 13) Miss = 1'b0;
         check_fill(16'h2460, c);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
